// File: rtl/eu_xbuf_arb.sv
// Tagged operand buffer between the interconnect and the ALU: one write or one consume-once read per cycle.
// Writes win by default; a read that has been starved STARVE_LIMIT cycles takes priority, A/B share round-robin.
module eu_xbuf_arb #(
   parameter int NUM_IDX_BITS = 2,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   input  logic [ADDR_WIDTH-1:0]   in_addr,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    in_ready,
   input  logic                    rd_a_valid,
   input  logic [ADDR_WIDTH-1:0]   rd_a_addr,
   output logic                    rd_a_grant,
   output logic                    rd_a_resp_valid,
   output logic [DATA_WIDTH-1:0]   rd_a_resp_data,
   input  logic                    rd_b_valid,
   input  logic [ADDR_WIDTH-1:0]   rd_b_addr,
   output logic                    rd_b_grant,
   output logic                    rd_b_resp_valid,
   output logic [DATA_WIDTH-1:0]   rd_b_resp_data,
   output logic                    full,
   output logic                    empty,
   output logic [NUM_IDX_BITS:0]   occupancy
);
   localparam int DEPTH = 2 ** NUM_IDX_BITS;

   typedef struct packed {
      logic                  vld;
      logic [ADDR_WIDTH-1:0] tag;
      logic [DATA_WIDTH-1:0] dat;
   } entry_t;

   entry_t                  tbl [DEPTH];
   logic [NUM_IDX_BITS:0]   occ;
   logic [2:0]              starve_cnt;
   logic                    last_b;

   logic                    dup, hit_a, hit_b, free_found;
   logic [NUM_IDX_BITS-1:0] idx_a, idx_b, free_idx;
   logic                    wr_elig, a_elig, b_elig, rd_elig, rd_win, rd_grant;

   always_comb begin
      dup        = 1'b0;
      hit_a      = 1'b0;
      hit_b      = 1'b0;
      free_found = 1'b0;
      idx_a      = '0;
      idx_b      = '0;
      free_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tbl[i].vld && tbl[i].tag == in_addr) dup = 1'b1;
         if (tbl[i].vld && tbl[i].tag == rd_a_addr) begin
            hit_a = 1'b1;
            idx_a = NUM_IDX_BITS'(i);
         end
         if (tbl[i].vld && tbl[i].tag == rd_b_addr) begin
            hit_b = 1'b1;
            idx_b = NUM_IDX_BITS'(i);
         end
         if (!tbl[i].vld && !free_found) begin
            free_found = 1'b1;
            free_idx   = NUM_IDX_BITS'(i);
         end
      end
   end

   // last_b set means B was served last, so A is favoured on a tie.
   always_comb begin
      wr_elig    = in_valid & ~full & ~dup;
      a_elig     = rd_a_valid & hit_a;
      b_elig     = rd_b_valid & hit_b;
      rd_elig    = a_elig | b_elig;
      rd_win     = rd_elig & (~wr_elig | (starve_cnt == 3'(STARVE_LIMIT)));
      in_ready   = wr_elig & ~rd_win;
      rd_a_grant = rd_win & a_elig & (~b_elig | last_b);
      rd_b_grant = rd_win & b_elig & (~a_elig | ~last_b);
      rd_grant   = rd_a_grant | rd_b_grant;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) tbl[i].vld <= 1'b0;
         occ             <= '0;
         starve_cnt      <= '0;
         last_b          <= 1'b1;
         rd_a_resp_valid <= 1'b0;
         rd_b_resp_valid <= 1'b0;
         rd_a_resp_data  <= '0;
         rd_b_resp_data  <= '0;
      end else begin
         rd_a_resp_valid <= rd_a_grant;
         rd_b_resp_valid <= rd_b_grant;
         if (rd_a_grant) begin
            rd_a_resp_data  <= tbl[idx_a].dat;
            tbl[idx_a].vld  <= 1'b0;
         end
         if (rd_b_grant) begin
            rd_b_resp_data  <= tbl[idx_b].dat;
            tbl[idx_b].vld  <= 1'b0;
         end
         if (in_ready) tbl[free_idx] <= '{vld: 1'b1, tag: in_addr, dat: in_data};

         if (in_ready)      occ <= occ + 1'b1;
         else if (rd_grant) occ <= occ - 1'b1;

         if (rd_grant || !rd_elig)
            starve_cnt <= '0;
         else if (in_ready && starve_cnt != 3'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;

         if (rd_grant) last_b <= ~last_b;
      end
   end

   assign occupancy = occ;
   assign full      = (occ == (NUM_IDX_BITS + 1)'(DEPTH));
   assign empty     = (occ == '0);
endmodule

// File: tb/tb_eu_xbuf_arb.sv
// Directed bench: a 4-entry and an 8-entry instance; grants checked in-cycle, responses via per-port scoreboards.
module tb_eu_xbuf_arb;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [2];
   logic        iv [2], av [2], bv [2];
   logic [7:0]  ia [2], aa [2], ba [2];
   logic [15:0] idt [2];
   logic        ir [2], ag [2], bg [2], arv [2], brv [2], fl [2], em [2];
   logic [15:0] ard [2], brd [2];
   logic [2:0]  occ4;
   logic [3:0]  occ8;

   int checks = 0;
   int errors = 0;
   logic [15:0] qa0 [$], qb0 [$], qa1 [$], qb1 [$];

   eu_xbuf_arb u4 (
      .clk(clk), .reset_n(rst_n[0]),
      .in_valid(iv[0]), .in_addr(ia[0]), .in_data(idt[0]), .in_ready(ir[0]),
      .rd_a_valid(av[0]), .rd_a_addr(aa[0]), .rd_a_grant(ag[0]),
      .rd_a_resp_valid(arv[0]), .rd_a_resp_data(ard[0]),
      .rd_b_valid(bv[0]), .rd_b_addr(ba[0]), .rd_b_grant(bg[0]),
      .rd_b_resp_valid(brv[0]), .rd_b_resp_data(brd[0]),
      .full(fl[0]), .empty(em[0]), .occupancy(occ4)
   );

   eu_xbuf_arb #(.NUM_IDX_BITS(3)) u8 (
      .clk(clk), .reset_n(rst_n[1]),
      .in_valid(iv[1]), .in_addr(ia[1]), .in_data(idt[1]), .in_ready(ir[1]),
      .rd_a_valid(av[1]), .rd_a_addr(aa[1]), .rd_a_grant(ag[1]),
      .rd_a_resp_valid(arv[1]), .rd_a_resp_data(ard[1]),
      .rd_b_valid(bv[1]), .rd_b_addr(ba[1]), .rd_b_grant(bg[1]),
      .rd_b_resp_valid(brv[1]), .rd_b_resp_data(brd[1]),
      .full(fl[1]), .empty(em[1]), .occupancy(occ8)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: a response is owed exactly when the scoreboard holds an entry for that port.
   task automatic mon(input string nm, input logic v, input logic [15:0] d,
                      input int qs, input logic [15:0] e);
      chk({nm, " resp_valid"}, v, qs > 0);
      if (qs > 0 && v) chk({nm, " resp_data"}, d, e);
   endtask

   always @(negedge clk) begin
      logic [15:0] e;
      e = '0; if (qa0.size() > 0) e = qa0[0]; mon("u4 a", arv[0], ard[0], qa0.size(), e);
      if (qa0.size() > 0) void'(qa0.pop_front());
      e = '0; if (qb0.size() > 0) e = qb0[0]; mon("u4 b", brv[0], brd[0], qb0.size(), e);
      if (qb0.size() > 0) void'(qb0.pop_front());
      e = '0; if (qa1.size() > 0) e = qa1[0]; mon("u8 a", arv[1], ard[1], qa1.size(), e);
      if (qa1.size() > 0) void'(qa1.pop_front());
      e = '0; if (qb1.size() > 0) e = qb1[0]; mon("u8 b", brv[1], brd[1], qb1.size(), e);
      if (qb1.size() > 0) void'(qb1.pop_front());
   end

   task automatic idle(input int d);
      iv[d] = 1'b0; ia[d] = '0; idt[d] = '0;
      av[d] = 1'b0; aa[d] = '0; bv[d] = 1'b0; ba[d] = '0;
   endtask

   // One bus cycle on instance d: drive, check combinational grants mid-cycle, log owed responses at the edge.
   task automatic step(input int d, input logic wv, input logic [7:0] wa, input logic [15:0] wd,
                       input logic va, input logic [7:0] ta, input logic vb, input logic [7:0] tb,
                       input logic e_ir, input logic e_ag, input logic e_bg,
                       input logic [15:0] e_ad, input logic [15:0] e_bd, input string nm);
      iv[d] = wv; ia[d] = wa; idt[d] = wd;
      av[d] = va; aa[d] = ta; bv[d] = vb; ba[d] = tb;
      @(negedge clk);
      chk({nm, " in_ready"}, ir[d], e_ir);
      chk({nm, " rd_a_grant"}, ag[d], e_ag);
      chk({nm, " rd_b_grant"}, bg[d], e_bg);
      @(posedge clk);
      if (e_ag) begin if (d == 0) qa0.push_back(e_ad); else qa1.push_back(e_ad); end
      if (e_bg) begin if (d == 0) qb0.push_back(e_bd); else qb1.push_back(e_bd); end
      #1;
      idle(d);
   endtask

   task automatic wr(input int d, input logic [7:0] wa, input logic [15:0] wd, input string nm);
      step(d, 1, wa, wd, 0, 0, 0, 0, 1, 0, 0, 0, 0, nm);
   endtask

   task automatic stat(input int d, input int eocc, input logic efull, input logic eempty, input string nm);
      chk({nm, " occupancy"}, (d == 0) ? 32'(occ4) : 32'(occ8), eocc);
      chk({nm, " full"}, fl[d], efull);
      chk({nm, " empty"}, em[d], eempty);
   endtask

   task automatic rst(input int d);
      idle(d);
      rst_n[d] = 1'b0;
      @(posedge clk); #1;
      rst_n[d] = 1'b1;
   endtask

   initial begin
      idle(0); idle(1);
      rst_n[0] = 1'b0; rst_n[1] = 1'b0;
      @(posedge clk); #1;
      stat(0, 0, 0, 1, "reset u4");
      stat(1, 0, 0, 1, "reset u8");
      chk("reset a resp_data", ard[0], 0);
      chk("reset b resp_data", brd[0], 0);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;

      // Basic write then consume-once read
      wr(0, 8'h11, 16'hBEEF, "t1 wr");
      stat(0, 1, 0, 1'b0, "t1 after wr");
      step(0, 0, 0, 0, 1, 8'h11, 0, 0, 0, 1, 0, 16'hBEEF, 0, "t1 rd");
      stat(0, 0, 0, 1, "t1 after rd");
      step(0, 0, 0, 0, 1, 8'h11, 0, 0, 0, 0, 0, 0, 0, "t1 consumed");

      // Fill to full; 5th write stalls until a read frees a slot
      for (int i = 0; i < 4; i++) wr(0, 8'hA0 + 8'(i), 16'h1000 + 16'(i), "t2 fill");
      stat(0, 4, 1, 0, "t2 full");
      step(0, 1, 8'hA4, 16'h10A4, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t2 stall");
      stat(0, 4, 1, 0, "t2 still full");
      step(0, 1, 8'hA4, 16'h10A4, 1, 8'hA2, 0, 0, 0, 1, 0, 16'h1002, 0, "t2 drain");
      stat(0, 3, 0, 0, "t2 after drain");
      step(0, 1, 8'hA4, 16'h10A4, 0, 0, 0, 0, 1, 0, 0, 0, 0, "t2 refill");
      stat(0, 4, 1, 0, "t2 refull");
      step(0, 0, 0, 0, 0, 0, 1, 8'hA4, 0, 0, 1, 0, 16'h10A4, "t2 rd new");

      // Duplicate tag stalls until the old copy is consumed
      rst(0);
      wr(0, 8'h30, 16'h3030, "t3 wr");
      step(0, 1, 8'h30, 16'h3131, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t3 dup");
      step(0, 1, 8'h30, 16'h3131, 1, 8'h30, 0, 0, 0, 1, 0, 16'h3030, 0, "t3 dup rd");
      step(0, 1, 8'h30, 16'h3131, 0, 0, 0, 0, 1, 0, 0, 0, 0, "t3 dup wr");
      step(0, 0, 0, 0, 0, 0, 1, 8'h30, 0, 0, 1, 0, 16'h3131, "t3 rd b");

      // Read of an absent tag waits for the write, then wins the next cycle
      step(0, 0, 0, 0, 0, 0, 1, 8'h22, 0, 0, 0, 0, 0, "t4 miss");
      step(0, 1, 8'h22, 16'h2222, 0, 0, 1, 8'h22, 1, 0, 0, 0, 0, "t4 wr");
      step(0, 0, 0, 0, 0, 0, 1, 8'h22, 0, 0, 1, 0, 16'h2222, "t4 hit");

      // Reset landing on the edge that would register a read response
      rst(0);
      wr(0, 8'h33, 16'h3300, "t5 wr33");
      wr(0, 8'h44, 16'h4400, "t5 wr44");
      av[0] = 1'b1; aa[0] = 8'h33; rst_n[0] = 1'b0;
      @(posedge clk); #1;
      rst_n[0] = 1'b1; idle(0);
      chk("t5 no resp_valid", arv[0], 0);
      chk("t5 resp_data", ard[0], 0);
      stat(0, 0, 0, 1, "t5 after reset");
      step(0, 0, 0, 0, 1, 8'h44, 1, 8'h33, 0, 0, 0, 0, 0, "t5 miss");

      // Starvation: four writes win, the fifth cycle goes to the read
      wr(1, 8'h50, 16'h5050, "t6 wr");
      for (int k = 0; k < 4; k++)
         step(1, 1, 8'h60 + 8'(k), 16'h6000 + 16'(k), 1, 8'h50, 0, 0, 1, 0, 0, 0, 0, "t6 starve");
      step(1, 1, 8'h64, 16'h6004, 1, 8'h50, 0, 0, 0, 1, 0, 16'h5050, 0, "t6 forced");
      stat(1, 4, 0, 0, "t6 occ");
      step(1, 1, 8'h64, 16'h6004, 1, 8'h60, 0, 0, 1, 0, 0, 0, 0, "t6 cleared");

      // Round-robin A,B,A,B then a shared-tag collision
      rst(1);
      for (int i = 1; i <= 5; i++) wr(1, 8'(i), 16'h0A00 + 16'(i), "t7 fill");
      step(1, 0, 0, 0, 1, 8'h01, 1, 8'h02, 0, 1, 0, 16'h0A01, 0, "t7 rr1");
      step(1, 0, 0, 0, 1, 8'h03, 1, 8'h02, 0, 0, 1, 0, 16'h0A02, "t7 rr2");
      step(1, 0, 0, 0, 1, 8'h03, 1, 8'h04, 0, 1, 0, 16'h0A03, 0, "t7 rr3");
      step(1, 0, 0, 0, 1, 8'h05, 1, 8'h04, 0, 0, 1, 0, 16'h0A04, "t7 rr4");
      step(1, 0, 0, 0, 1, 8'h05, 1, 8'h05, 0, 1, 0, 16'h0A05, 0, "t7 same tag");
      step(1, 0, 0, 0, 0, 0, 1, 8'h05, 0, 0, 0, 0, 0, "t7 loser misses");
      stat(1, 0, 0, 1, "t7 empty");

      repeat (2) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
